// File: rtl/indec_with_delims_if.sv
// Bus interface for indec_with_delims.
// Carries the UART receive line into the parser and the parsed number back out.
//   inchan       : UART rxd, idle high, asynchronous to clk
//   result       : parsed value, modulo 2^W
//   result_ready : parser idle with a valid result, and no start this cycle
//   overflow     : the true value did not fit in W bits
//   term_byte    : the non-digit byte that ended the number
// master = caller side, slave = indec_with_delims side.
interface indec_with_delims_if #(
  parameter int W = 16
);
  logic         inchan;
  logic [W-1:0] result;
  logic         result_ready;
  logic         overflow;
  logic [7:0]   term_byte;

  modport master (
    output inchan,
    input  result,
    input  result_ready,
    input  overflow,
    input  term_byte
  );

  modport slave (
    input  inchan,
    output result,
    output result_ready,
    output overflow,
    output term_byte
  );
endinterface

// File: rtl/indec_with_delims.sv
// indec_with_delims: 8N1 UART receiver feeding an ASCII decimal parser.
// A caller pulses start, waits for result_ready, then reads result.
// Leading non-digits are skipped; the first non-digit after a digit ends the number.
// Ports:
//   clk   : system clock, rising edge
//   start : synchronous active-high reset / restart of a parse
//   bus   : indec_with_delims_if slave (inchan in; result, result_ready,
//           overflow, term_byte out)
module indec_with_delims #(
  parameter int CLKS_PER_BIT = 868,
  parameter int W            = 16
) (
  input  logic                  clk,
  input  logic                  start,
  indec_with_delims_if.slave    bus
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {P_READY = 2'd0, P_HUNT = 2'd1, P_DIGITS = 2'd2} pstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rstate_t;

  // Power-up values: parser idle and ready with a zero result.
  pstate_t          pstate     = P_READY;
  pstate_t          pstate_nx;
  rstate_t          rstate     = R_IDLE;
  rstate_t          rstate_nx;
  logic             sync1      = 1'b1;
  logic             rx_s       = 1'b1;
  logic             rx_prev    = 1'b1;
  logic [CNT_W-1:0] cnt        = '0;
  logic [2:0]       bit_idx    = 3'd0;
  logic [7:0]       shreg      = 8'd0;
  logic [W-1:0]     acc        = '0;
  logic [W-1:0]     result_r   = '0;
  logic             overflow_r = 1'b0;
  logic [7:0]       term_r     = 8'd0;
  logic             ready_s;

  logic             rx_run;
  logic             rx_hold;
  logic             cnt_zero;
  logic             byte_valid;
  logic             is_digit;
  logic [W+3:0]     wide;

  // The receiver only listens while a parse is in progress.
  assign rx_run     = (pstate != P_READY);
  assign rx_hold    = start || !rx_run;
  assign cnt_zero   = (cnt == '0);
  // Stop-bit sample cycle with a good stop bit; a low stop bit drops the byte.
  assign byte_valid = (rstate == R_STOP) && cnt_zero && rx_s;
  assign is_digit   = (shreg >= 8'h30) && (shreg <= 8'h39);
  // acc*10 + digit at W+4 bits so bits above W reveal overflow.
  assign wide       = (W+4)'(acc) * (W+4)'(4'd10) + (W+4)'(shreg[3:0]);

  // Two-flop synchronizer on inchan plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (start) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= bus.inchan;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // State registers for the receiver and parser FSMs.
  always_ff @(posedge clk) begin
    rstate <= rstate_nx;
    pstate <= pstate_nx;
  end

  // Receiver next-state logic.
  always_comb begin
    rstate_nx = rstate;
    if (rx_hold) begin
      rstate_nx = R_IDLE;
    end else begin
      case (rstate)
        R_IDLE:  rstate_nx = (rx_prev && !rx_s) ? R_START : R_IDLE;
        // A start bit that is high again at mid-bit was a glitch.
        R_START: rstate_nx = cnt_zero ? (rx_s ? R_IDLE : R_DATA) : R_START;
        R_DATA:  rstate_nx = (cnt_zero && (bit_idx == 3'd7)) ? R_STOP : R_DATA;
        R_STOP:  rstate_nx = cnt_zero ? R_IDLE : R_STOP;
        default: rstate_nx = R_IDLE;
      endcase
    end
  end

  // Receiver bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rx_hold) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else begin
      case (rstate)
        R_IDLE: begin
          // Preloaded every idle cycle so the start bit is checked at mid-bit.
          cnt     <= CNT_HALF;
          bit_idx <= 3'd0;
        end
        R_DATA: begin
          if (cnt_zero) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= CNT_FULL;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: cnt <= cnt_zero ? CNT_FULL : (cnt - CNT_ONE);
      endcase
    end
  end

  // Parser next-state logic; start always wins over a byte arriving in the same cycle.
  always_comb begin
    pstate_nx = pstate;
    if (start) begin
      pstate_nx = P_HUNT;
    end else begin
      case (pstate)
        P_READY:  pstate_nx = P_READY;
        P_HUNT:   pstate_nx = (byte_valid && is_digit) ? P_DIGITS : P_HUNT;
        P_DIGITS: pstate_nx = (byte_valid && !is_digit) ? P_READY : P_DIGITS;
        default:  pstate_nx = P_READY;
      endcase
    end
  end

  // Parser datapath: accumulate digits, latch result and terminator on a non-digit.
  always_ff @(posedge clk) begin
    if (start) begin
      acc        <= '0;
      overflow_r <= 1'b0;
      term_r     <= 8'd0;
    end else if (byte_valid) begin
      case (pstate)
        P_HUNT: begin
          if (is_digit) begin
            acc <= W'(shreg[3:0]);
          end
        end
        P_DIGITS: begin
          if (is_digit) begin
            acc        <= wide[W-1:0];
            overflow_r <= overflow_r | (|wide[W+3:W]);
          end else begin
            result_r <= acc;
            term_r   <= shreg;
          end
        end
        default: ;
      endcase
    end
  end

  // Parser output logic: ready drops in the same cycle start is raised.
  always_comb begin
    ready_s = 1'b0;
    if ((pstate == P_READY) && !start) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign bus.result       = result_r;
  assign bus.result_ready = ready_s;
  assign bus.overflow     = overflow_r;
  assign bus.term_byte    = term_r;

endmodule

// File: tb/tb_indec_with_delims.sv
// Directed self-checking bench for indec_with_delims (CLKS_PER_BIT = 16, W = 16).
// Bytes are driven 8N1 at exact bit time; each frame lasts 160 clock edges.
// With the frame's start bit driven just after edge 0, the stop bit is sampled
// in the cycle ending at edge 155, so a terminator makes result_ready high from
// sample 155 through 160 (6 samples).
module tb_indec_with_delims;

  localparam int CPB = 16;
  localparam int W   = 16;

  logic clk   = 1'b0;
  logic start = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  indec_with_delims_if #(.W(W)) bus ();

  indec_with_delims #(.CLKS_PER_BIT(CPB), .W(W)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  // Drive one frame; optionally pulse start at sample start_at (0 = never).
  // rise_n = first sample with result_ready high, hi_cnt = samples with it high.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int start_at,
                           output int rise_n, output int hi_cnt);
    logic [9:0] frame;
    frame  = {stop_bit, b, 1'b0};
    rise_n = 0;
    hi_cnt = 0;
    bus.inchan = frame[0];
    for (int n = 1; n <= 10 * CPB; n++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if ((n % CPB == 0) && (n < 10 * CPB)) bus.inchan = frame[n / CPB];
      if (n == start_at) begin
        start = 1'b1;
        #1;
        n_cmp++;
        if (bus.result_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL ready_drop_mid_byte: result_ready %b, expected 0", bus.result_ready);
        end
      end
      if (bus.result_ready === 1'b1) begin
        hi_cnt++;
        if (rise_n == 0) rise_n = n;
      end
    end
    bus.inchan = 1'b1;
  endtask

  task automatic idle(input int bits);
    bus.inchan = 1'b1;
    repeat (bits * CPB) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    #1;
    n_cmp++;
    if (bus.result_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_in_start_cycle: result_ready %b, expected 0", bus.result_ready);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    n_cmp++;
    if (bus.result_ready !== 1'b0 || bus.overflow !== 1'b0 || bus.term_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL after_start: ready %b ovf %b term %h, expected 0 0 00",
               bus.result_ready, bus.overflow, bus.term_byte);
    end
  endtask

  // Send a string whose last character terminates the number.
  task automatic send_seq(input string s);
    int r;
    int h;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1, 0, r, h);
      n_cmp++;
      if (i < s.len() - 1) begin
        if (h !== 0) begin
          n_bad++;
          $display("FAIL ready_low_during_rx: byte %0d ready-high samples %0d, expected 0", i, h);
        end
        idle(2);
      end else begin
        if (r !== 155 || h !== 6) begin
          n_bad++;
          $display("FAIL ready_rise_timing: first high %0d count %0d, expected 155 6", r, h);
        end
        idle(1);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.result_ready !== 1'b1 || bus.result !== 16'h0000 ||
        bus.overflow !== 1'b0 || bus.term_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: ready %b result %h ovf %b term %h, expected 1 0000 0 00",
               bus.result_ready, bus.result, bus.overflow, bus.term_byte);
    end
  endtask

  task automatic test_ignored_when_ready();
    string s;
    int r;
    int h;
    s = "12\r";
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1, 0, r, h);
      n_cmp++;
      if (h !== 10 * CPB) begin
        n_bad++;
        $display("FAIL ready_idle_ignore: byte %0d ready-high samples %0d, expected 160", i, h);
      end
      idle(2);
    end
    n_cmp++;
    if (bus.result !== 16'h0000 || bus.term_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL idle_result: result %h term %h, expected 0000 00", bus.result, bus.term_byte);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    send_seq("123\r");
    n_cmp++;
    if (bus.result !== 16'h007B || bus.overflow !== 1'b0 || bus.term_byte !== 8'h0D) begin
      n_bad++;
      $display("FAIL basic_123: result %h ovf %b term %h, expected 007b 0 0d",
               bus.result, bus.overflow, bus.term_byte);
    end
  endtask

  task automatic test_leading_delims();
    pulse_start();
    n_cmp++;
    if (bus.result !== 16'h007B) begin
      n_bad++;
      $display("FAIL result_hold_on_start: result %h, expected 007b", bus.result);
    end
    send_seq("\r\n 65535\n");
    n_cmp++;
    if (bus.result !== 16'hFFFF || bus.overflow !== 1'b0 || bus.term_byte !== 8'h0A) begin
      n_bad++;
      $display("FAIL max_65535: result %h ovf %b term %h, expected ffff 0 0a",
               bus.result, bus.overflow, bus.term_byte);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    send_seq("65536\r");
    n_cmp++;
    if (bus.result !== 16'h0000 || bus.overflow !== 1'b1 || bus.term_byte !== 8'h0D) begin
      n_bad++;
      $display("FAIL overflow_65536: result %h ovf %b term %h, expected 0000 1 0d",
               bus.result, bus.overflow, bus.term_byte);
    end
    pulse_start();
    send_seq("7\r");
    n_cmp++;
    if (bus.result !== 16'h0007 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL after_overflow_7: result %h ovf %b, expected 0007 0", bus.result, bus.overflow);
    end
  endtask

  task automatic test_restart_mid_byte();
    int r;
    int h;
    pulse_start();
    send_byte(8'h39, 1'b1, 0, r, h);
    idle(2);
    send_byte(8'h38, 1'b1, 0, r, h);
    idle(2);
    // start lands in data bit 2 of '7'; the byte must not reach the parser.
    send_byte(8'h37, 1'b1, 3 * CPB + 8, r, h);
    n_cmp++;
    if (h !== 0) begin
      n_bad++;
      $display("FAIL ready_low_after_restart: ready-high samples %0d, expected 0", h);
    end
    idle(8);
    send_seq("4\r");
    n_cmp++;
    if (bus.result !== 16'h0004 || bus.term_byte !== 8'h0D) begin
      n_bad++;
      $display("FAIL restart_result: result %h term %h, expected 0004 0d", bus.result, bus.term_byte);
    end
  endtask

  task automatic test_framing_and_glitch();
    int r;
    int h;
    pulse_start();
    send_byte(8'h35, 1'b0, 0, r, h);
    idle(2);
    bus.inchan = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.inchan = 1'b1;
    idle(2);
    send_seq("2,");
    n_cmp++;
    if (bus.result !== 16'h0002 || bus.term_byte !== 8'h2C || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL framing_glitch: result %h term %h ovf %b, expected 0002 2c 0",
               bus.result, bus.term_byte, bus.overflow);
    end
  endtask

  initial begin
    bus.inchan = 1'b1;
    test_reset();
    test_ignored_when_ready();
    test_basic();
    test_leading_delims();
    test_overflow();
    test_restart_mid_byte();
    test_framing_and_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/indec_with_delims.md
Name: indec_with_delims

Overview:
- Receive-side counterpart of the decimal-printing UART path. Bit-level 8N1 receiver on the rxd line parses an ASCII decimal number and returns it as a binary value with a ready flag.
- Runs as a callable sub-block: a caller pulses start, waits for result_ready, then reads result.
- Typical use: numeric parameters typed by a user, e.g. "1234<CR>", on the ATLYS in_uart_rxd pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 8.
- W, 16, width of the result.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- start  input  1  synchronous, active-high reset and restart, sampled on clk. Reset is synchronous and active-high.
- inchan  input  1  UART rxd; idle high; asynchronous to clk.
- result  output  W  parsed value, modulo 2^W.
- result_ready  output  1  equals the internal ready state AND NOT start.
- overflow  output  1  high if the true value exceeded 2^W-1.
- term_byte  output  8  the byte that ended the number.

Behaviour:
- Power-up register initial values: state = READY, result = 0, overflow = 0, term_byte = 0. After power-up and before any start, result_ready = 1.
- start = 1 (any cycle, any state):
  - next state is HUNT; the receiver returns to line-idle wait; accumulator, digit count, overflow and term_byte are cleared to 0.
  - result_ready drops combinationally in the same cycle.
  - result holds its old value until a new number completes.
- Input synchronizer: two flops on inchan (reset to 1) give rx_s. A third flop holds the previous rx_s for edge detection.
- Receiver states: IDLE, STARTBIT, DATA, STOPBIT.
  - IDLE: falling edge on rx_s (previous 1, current 0) -> STARTBIT, bit counter = CLKS_PER_BIT/2 - 1.
  - STARTBIT: on counter expiry, if rx_s = 0 -> DATA; otherwise treat as a glitch and return to IDLE.
  - DATA: sample 8 bits, LSB first, one every CLKS_PER_BIT cycles.
  - STOPBIT: sample one more bit after CLKS_PER_BIT cycles.
    - Stop bit = 1: one-cycle byte_valid with the data byte.
    - Stop bit = 0: framing error; the byte is discarded and there is no byte_valid.
  - After any STOPBIT the receiver returns to IDLE. A new start needs rx_s high, so a line held low never retriggers.
  - The receiver runs only in parser states HUNT and DIGITS; in READY, input bytes are ignored.
- Parser states: READY, HUNT, DIGITS.
  - HUNT, byte is '0'..'9' (0x30..0x39): acc = digit, state -> DIGITS.
  - HUNT, any other byte: ignored (leading CR/LF/space skipped).
  - DIGITS, byte is a digit: acc <= acc*10 + (byte-0x30).
    - Compute at W+4 bits. Keep the low W bits.
    - Set overflow (sticky) if the upper bits are nonzero or overflow is already set.
  - DIGITS, byte is not a digit: ends the number.
    - result <= acc, term_byte <= byte, state -> READY.
    - Any non-digit terminates, not only 0x0D/0x0A.
- Latency: each update lands on the clock edge after the cycle of the stop-bit sample.
  - acc updates on that edge.
  - For a terminator, result, term_byte and READY update on that edge, so result_ready is high from the next cycle.
  - The worst-case path (multiply by 10 plus add) completes in that single cycle.
- Simultaneous start and byte_valid: start wins; the byte is dropped.
- A number with more than W/3 digits is legal. Wrap-around is reported only through overflow.

Test Plan (CLKS_PER_BIT = 16, W = 16, bytes sent 8N1 at exact bit time):
- start pulse, then "123\r":
  - result = 123 (0x007B), overflow = 0, term_byte = 0x0D.
  - result_ready rises 1 cycle after the '\r' stop-bit sample and is low throughout reception.
- start, then "\r\n 65535\n": result = 0xFFFF, overflow = 0, term_byte = 0x0A.
- start, then "65536\r": result = 0x0000, overflow = 1. Then start, "7\r": result = 7, overflow = 0.
- start, "98", start pulse during the 3rd bit of the next byte, then "4\r":
  - result = 4.
  - result_ready = 0 during the start cycle and stays 0 until '\r' completes.
- start, byte '5' sent with stop bit = 0, then "2," :
  - result = 2, term_byte = 0x2C.
  - A 5-cycle low glitch on inchan between bytes produces no byte.
- No start after power-up, "12\r" on the line: result_ready stays 1, result stays 0, no state change.
